// File: rtl/execute_stage_v2_pkg.sv
// Shared types for the RV32 execute stage: ALU ops, branch conditions,
// forwarding selects, multiplier states and the ID/EX control payload.
package exec_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_W      = 2'b01,
      FWD_M      = 2'b10,
      FWD_RF_ALT = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic       alu_src;
      logic       mul;
      logic [1:0] result_src;
      alu_op_t    alu_op;
      logic [2:0] funct3;
   } ex_ctrl_t;

endpackage

// File: rtl/execute_stage_v2_mul_iter.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Busy from start until DONE; DONE lasts one cycle then returns to IDLE.
module mul_iter
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int unsigned CW = $clog2(WIDTH);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc;
   logic             launch;

   assign launch  = (state_q == MUL_IDLE) && start_i && !flush_i;
   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= MUL_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = MUL_IDLE;
      end else begin
         case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_inc == CW'(WIDTH-1)) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o    = (state_q != MUL_DONE);
      done_o    = (state_q == MUL_DONE);
      product_o = acc_q;
   end

   // The launch cycle folds in b[0] so WIDTH-1 BUSY steps cover bits 1..WIDTH-1.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (launch) begin
         mcand_d  = a_i << 1;
         mplier_d = b_i >> 1;
         acc_d    = b_i[0] ? a_i : '0;
         cnt_d    = '0;
      end else if (state_q == MUL_BUSY) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/execute_stage_v2.sv
// RV32 execute stage: ID/EX register, operand forwarding, ALU, branch/jump
// resolution and an optional iterative multiplier that holds E while busy.
module execute_stage_v2
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned REG_AW = 5,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic [WIDTH-1:0]  RD1D,
   input  logic [WIDTH-1:0]  RD2D,
   input  logic [WIDTH-1:0]  PCD,
   input  logic [WIDTH-1:0]  ImmExtD,
   input  logic [WIDTH-1:0]  PCPlus4D,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic              JalrD,
   input  logic              ALUSrcD,
   input  logic              MulD,
   input  logic [1:0]        ResultSrcD,
   input  logic [3:0]        ALUControlD,
   input  logic [2:0]        Funct3D,
   input  logic [1:0]        ForwardAE,
   input  logic [1:0]        ForwardBE,
   input  logic [WIDTH-1:0]  ALUResultM,
   input  logic [WIDTH-1:0]  ResultW,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic [1:0]        ResultSrcE,
   output logic [REG_AW-1:0] RdE,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [WIDTH-1:0]  ALUResultE,
   output logic [WIDTH-1:0]  WriteDataE,
   output logic [WIDTH-1:0]  PCPlus4E,
   output logic [WIDTH-1:0]  PCTargetE,
   output logic              PCSrcE,
   output logic              MulBusyE
);

   localparam int unsigned SHW = $clog2(WIDTH);

   ex_ctrl_t          ctrl_q, ctrl_d;
   logic [WIDTH-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, pc_q, pc_d;
   logic [WIDTH-1:0]  imm_q, imm_d, pcp4_q, pcp4_d;
   logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

   logic [WIDTH-1:0]  fwd_a, fwd_b, src_b, sum, alu_res;
   logic [SHW-1:0]    shamt;
   logic              taken, mul_e, mul_busy, mul_done;
   logic [WIDTH-1:0]  mul_prod;

   // ID/EX next state: flush beats stall; a busy multiply holds like a stall.
   always_comb begin
      ctrl_d = ctrl_q;
      rd1_d  = rd1_q;
      rd2_d  = rd2_q;
      pc_d   = pc_q;
      imm_d  = imm_q;
      pcp4_d = pcp4_q;
      rs1_d  = rs1_q;
      rs2_d  = rs2_q;
      rd_d   = rd_q;
      if (FlushE) begin
         ctrl_d = '0;
         rd1_d  = '0;
         rd2_d  = '0;
         pc_d   = '0;
         imm_d  = '0;
         pcp4_d = '0;
         rs1_d  = '0;
         rs2_d  = '0;
         rd_d   = '0;
      end else if (!(StallE || MulBusyE)) begin
         ctrl_d = '{reg_write:  RegWriteD,
                    mem_write:  MemWriteD,
                    jump:       JumpD,
                    branch:     BranchD,
                    jalr:       JalrD,
                    alu_src:    ALUSrcD,
                    mul:        MulD,
                    result_src: ResultSrcD,
                    alu_op:     alu_op_t'(ALUControlD),
                    funct3:     Funct3D};
         rd1_d  = RD1D;
         rd2_d  = RD2D;
         pc_d   = PCD;
         imm_d  = ImmExtD;
         pcp4_d = PCPlus4D;
         rs1_d  = Rs1D;
         rs2_d  = Rs2D;
         rd_d   = RdD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         pc_q   <= '0;
         imm_q  <= '0;
         pcp4_q <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         pc_q   <= pc_d;
         imm_q  <= imm_d;
         pcp4_q <= pcp4_d;
         rs1_q  <= rs1_d;
         rs2_q  <= rs2_d;
         rd_q   <= rd_d;
      end
   end

   always_comb begin
      case (fwd_sel_t'(ForwardAE))
         FWD_W:   fwd_a = ResultW;
         FWD_M:   fwd_a = ALUResultM;
         default: fwd_a = rd1_q;
      endcase
      case (fwd_sel_t'(ForwardBE))
         FWD_W:   fwd_b = ResultW;
         FWD_M:   fwd_b = ALUResultM;
         default: fwd_b = rd2_q;
      endcase
   end

   assign src_b = ctrl_q.alu_src ? imm_q : fwd_b;
   assign sum   = fwd_a + src_b;
   assign shamt = src_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (ctrl_q.alu_op)
         ALU_ADD:  alu_res = sum;
         ALU_SUB:  alu_res = fwd_a - src_b;
         ALU_AND:  alu_res = fwd_a & src_b;
         ALU_OR:   alu_res = fwd_a | src_b;
         ALU_XOR:  alu_res = fwd_a ^ src_b;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (fwd_a < src_b)};
         ALU_SLL:  alu_res = fwd_a << shamt;
         ALU_SRL:  alu_res = fwd_a >> shamt;
         ALU_SRA:  alu_res = $signed(fwd_a) >>> shamt;
         ALU_LUI:  alu_res = src_b;
         default:  alu_res = '0;
      endcase
   end

   // Branches compare the two register operands, independent of ALUSrc.
   always_comb begin
      taken = 1'b0;
      case (ctrl_q.funct3)
         F3_BEQ:  taken = (fwd_a == fwd_b);
         F3_BNE:  taken = (fwd_a != fwd_b);
         F3_BLT:  taken = ($signed(fwd_a) <  $signed(fwd_b));
         F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
         F3_BLTU: taken = (fwd_a <  fwd_b);
         F3_BGEU: taken = (fwd_a >= fwd_b);
         default: taken = 1'b0;
      endcase
   end

   assign mul_e = ctrl_q.mul & MUL_EN;

   generate
      if (MUL_EN) begin : g_mul
         mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (mul_e),
            .flush_i   (FlushE),
            .a_i       (fwd_a),
            .b_i       (fwd_b),
            .busy_o    (mul_busy),
            .done_o    (mul_done),
            .product_o (mul_prod)
         );
      end else begin : g_no_mul
         assign mul_busy = 1'b0;
         assign mul_done = 1'b0;
         assign mul_prod = '0;
      end
   endgenerate

   assign MulBusyE   = mul_e & mul_busy;
   assign ALUResultE = (mul_e & mul_done) ? mul_prod : alu_res;
   assign WriteDataE = fwd_b;
   assign PCTargetE  = ctrl_q.jalr ? {sum[WIDTH-1:1], 1'b0} : (pc_q + imm_q);
   assign PCSrcE     = (ctrl_q.jump | (ctrl_q.branch & taken)) & ~MulBusyE;
   assign RegWriteE  = ctrl_q.reg_write & ~MulBusyE;
   assign MemWriteE  = ctrl_q.mem_write & ~MulBusyE;
   assign ResultSrcE = ctrl_q.result_src;
   assign RdE        = rd_q;
   assign Rs1E       = rs1_q;
   assign Rs2E       = rs2_q;
   assign PCPlus4E   = pcp4_q;

endmodule

// File: tb/tb_execute_stage_v2.sv
// Directed bench for execute_stage_v2: forwarding, ALU ops, branches, JALR,
// stall/flush, iterative multiply timing, flush and reset during a multiply.
module tb_execute_stage_v2;

   logic        clk, rst_n, StallE, FlushE;
   logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        RegWriteD, MemWriteD, JumpD, BranchD, JalrD, ALUSrcD, MulD;
   logic [1:0]  ResultSrcD;
   logic [3:0]  ALUControlD;
   logic [2:0]  Funct3D;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUResultM, ResultW;
   logic        RegWriteE, MemWriteE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  RdE, Rs1E, Rs2E;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
   logic        PCSrcE, MulBusyE;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0]  alu_ops [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
   logic [31:0] alu_exp [11] = '{32'hFFFF_FFEE, 32'h0000_0000, 32'hFFFF_FFF2, 32'hFFFF_FFF2,
                                 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFC0, 32'h3FFF_FFFC,
                                 32'hFFFF_FFFC, 32'h0000_0002, 32'h0000_0000};
   logic [2:0]  br_f3  [7]  = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010};
   logic        br_exp [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   execute_stage_v2 dut (
      .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .JalrD(JalrD), .ALUSrcD(ALUSrcD), .MulD(MulD), .ResultSrcD(ResultSrcD),
      .ALUControlD(ALUControlD), .Funct3D(Funct3D),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
      .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .MulBusyE(MulBusyE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0; PCPlus4D = '0;
      Rs1D = '0; Rs2D = '0; RdD = '0;
      RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; JalrD = 0;
      ALUSrcD = 0; MulD = 0; ResultSrcD = '0; ALUControlD = '0; Funct3D = '0;
   endtask

   initial begin
      rst_n = 0; StallE = 0; FlushE = 0;
      ForwardAE = '0; ForwardBE = '0; ALUResultM = '0; ResultW = '0;
      clear_d();
      #3;
      chk("rst_alu",     ALUResultE, 32'h0);
      chk("rst_regwr",   32'(RegWriteE), 32'h0);
      chk("rst_mulbusy", 32'(MulBusyE), 32'h0);
      chk("rst_pcsrc",   32'(PCSrcE), 32'h0);
      chk("rst_target",  PCTargetE, 32'h0);
      @(negedge clk);
      rst_n = 1;

      // forwarding from M, then W, then the alternate register-file select
      RD1D = 32'd5; ForwardAE = 2'b10; ALUResultM = 32'd100; ALUControlD = 4'd0;
      ALUSrcD = 1; ImmExtD = 32'd3; RegWriteD = 1; RdD = 5'd9; PCPlus4D = 32'h44;
      tick();
      chk("fwd_m_add",  ALUResultE, 32'd103);
      chk("fwd_regwr",  32'(RegWriteE), 32'h1);
      chk("fwd_rd",     32'(RdE), 32'd9);
      chk("fwd_pcp4",   PCPlus4E, 32'h44);
      ForwardAE = 2'b01; ResultW = 32'd200; #1;
      chk("fwd_w_add",  ALUResultE, 32'd203);
      ForwardAE = 2'b11; #1;
      chk("fwd_rf_alt", ALUResultE, 32'd8);
      ForwardBE = 2'b10; #1;
      chk("fwd_b_m",    WriteDataE, 32'd100);
      ForwardAE = '0; ForwardBE = '0;

      // ALU op table with SrcA=-16, SrcB=2
      clear_d();
      RD1D = 32'hFFFF_FFF0; RD2D = 32'd2;
      for (int i = 0; i < 11; i++) begin
         ALUControlD = alu_ops[i];
         tick();
         chk($sformatf("alu_op%0d", alu_ops[i]), ALUResultE, alu_exp[i]);
      end

      // branch conditions with SrcA=-1, SrcB=1
      clear_d();
      BranchD = 1; RD1D = 32'hFFFF_FFFF; RD2D = 32'd1; PCD = 32'h40; ImmExtD = 32'h10;
      for (int i = 0; i < 7; i++) begin
         Funct3D = br_f3[i];
         tick();
         chk($sformatf("br_f3_%0b", br_f3[i]), 32'(PCSrcE), 32'(br_exp[i]));
      end
      chk("br_target", PCTargetE, 32'h50);

      clear_d();
      JalrD = 1; JumpD = 1; RD1D = 32'h1003; ImmExtD = 32'h0; ALUSrcD = 1;
      tick();
      chk("jalr_target", PCTargetE, 32'h1002);
      chk("jalr_pcsrc",  32'(PCSrcE), 32'h1);

      // stall holds for three cycles, then the pending inputs load
      clear_d();
      RD1D = 32'd10; RD2D = 32'd20; RegWriteD = 1; RdD = 5'd7;
      tick();
      chk("stall_pre", ALUResultE, 32'd30);
      RD1D = 32'd1; RdD = 5'd8; StallE = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_alu", ALUResultE, 32'd30);
         chk("stall_rd",  32'(RdE), 32'd7);
      end
      StallE = 0;
      tick();
      chk("stall_rel", ALUResultE, 32'd21);
      chk("stall_rd2", 32'(RdE), 32'd8);

      StallE = 1; FlushE = 1;
      tick();
      chk("fs_regwr", 32'(RegWriteE), 32'h0);
      chk("fs_rd",    32'(RdE), 32'h0);
      chk("fs_alu",   ALUResultE, 32'h0);
      StallE = 0; FlushE = 0;

      // 7*6: 32 busy cycles, result on cycle 33; forwarding disturbed mid-BUSY
      clear_d();
      MulD = 1; RD1D = 32'd7; RD2D = 32'd6; RegWriteD = 1; RdD = 5'd3;
      tick();
      clear_d();
      for (int c = 1; c <= 32; c++) begin
         chk($sformatf("mul1_busy_c%0d", c), {30'b0, MulBusyE, RegWriteE}, 32'b10);
         if (c == 2) begin
            ForwardAE = 2'b10; ForwardBE = 2'b10; ALUResultM = 32'd999;
         end
         if (c == 32) begin
            ForwardAE = '0; ForwardBE = '0;
            MulD = 1; RD1D = 32'hFFFF_FFFF; RD2D = 32'd2; RegWriteD = 1; RdD = 5'd4;
         end
         tick();
      end
      chk("mul1_result", ALUResultE, 32'd42);
      chk("mul1_regwr",  32'(RegWriteE), 32'h1);
      chk("mul1_nbusy",  32'(MulBusyE), 32'h0);
      chk("mul1_rd",     32'(RdE), 32'd3);
      tick();
      chk("mul2_busy_c1", 32'(MulBusyE), 32'h1);
      clear_d();
      repeat (31) tick();
      chk("mul2_busy_c32", 32'(MulBusyE), 32'h1);
      MulD = 1; RD1D = 32'd7; RD2D = 32'd6; RegWriteD = 1;
      tick();
      chk("mul2_result", ALUResultE, 32'hFFFF_FFFE);
      chk("mul2_regwr",  32'(RegWriteE), 32'h1);

      // flush on busy cycle 10, then an add completes normally
      tick();
      repeat (9) tick();
      chk("mfl_busy_c10", 32'(MulBusyE), 32'h1);
      FlushE = 1;
      clear_d();
      RD1D = 32'd5; RD2D = 32'd6; RegWriteD = 1; RdD = 5'd4;
      tick();
      chk("mfl_nbusy", 32'(MulBusyE), 32'h0);
      chk("mfl_alu",   ALUResultE, 32'h0);
      chk("mfl_regwr", 32'(RegWriteE), 32'h0);
      chk("mfl_rd",    32'(RdE), 32'h0);
      FlushE = 0;
      tick();
      chk("mfl_add",   ALUResultE, 32'd11);
      chk("mfl_add_w", 32'(RegWriteE), 32'h1);
      chk("mfl_add_b", 32'(MulBusyE), 32'h0);

      // asynchronous reset during BUSY
      clear_d();
      MulD = 1; RD1D = 32'd3; RD2D = 32'd5; RegWriteD = 1;
      tick();
      clear_d();
      repeat (4) tick();
      chk("rmb_busy", 32'(MulBusyE), 32'h1);
      rst_n = 0;
      #1;
      chk("rmb_nbusy", 32'(MulBusyE), 32'h0);
      chk("rmb_alu",   ALUResultE, 32'h0);
      chk("rmb_regwr", 32'(RegWriteE), 32'h0);
      @(negedge clk);
      rst_n = 1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_stage_v2.md
Name: execute_stage_v2

Overview:
Parametrised execute stage for the pipelined RV32 core. It contains the ID/EX pipeline register with stall and flush controls, and operand forwarding muxes. It also holds an extended ALU, branch/jump resolution producing PCSrcE/PCTargetE, and an optional iterative multiplier that holds the instruction in E until its result is ready. Sits between decode and the EX/MEM register; hazard unit drives StallE/FlushE/Forward*E and consumes MulBusyE.

Parameters:
WIDTH, 32, datapath width
REG_AW, 5, register-address width
MUL_EN, 1, 1 = multiplier present; 0 = MulD ignored, MulBusyE tied 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold ID/EX register contents
FlushE  in  1  load bubble into ID/EX register
RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  WIDTH each  decode-stage operands/PC values
Rs1D, Rs2D, RdD  in  REG_AW each  register addresses
RegWriteD, MemWriteD, JumpD, BranchD, JalrD, ALUSrcD, MulD  in  1 each  decode controls
ResultSrcD  in  2  result select
ALUControlD  in  4  ALU op
Funct3D  in  3  branch condition
ForwardAE, ForwardBE  in  2 each  forward select
ALUResultM, ResultW  in  WIDTH each  forwarded values from M / W
RegWriteE, MemWriteE  out  1 each  gated controls to EX/MEM
ResultSrcE  out  2  result select
RdE, Rs1E, Rs2E  out  REG_AW each  to EX/MEM and hazard unit
ALUResultE, WriteDataE, PCPlus4E, PCTargetE  out  WIDTH each  results
PCSrcE  out  1  redirect fetch to PCTargetE
MulBusyE  out  1  multiply in progress; hazard unit must stall F/D/E

Behaviour:
- Reset (rst_n=0, async): all ID/EX fields 0 (bubble); FSM IDLE; counter 0. Outputs: all 0, PCSrcE=0, MulBusyE=0.
- ID/EX register on posedge: FlushE → all fields 0; else StallE or MulBusyE → hold; else load D inputs. Flush beats stall.
- Forwarding: 00 → RDxE, 01 → ResultW, 10 → ALUResultM, 11 → RDxE. SrcA = fwdA; WriteDataE = fwdB; SrcB = ALUSrcE ? ImmExtE : fwdB.
- ALU (combinational, ALUResultE when not MulE):
  - 0 add; 1 sub; 2 and; 3 or; 4 xor.
  - 5 slt (signed); 6 sltu. Both produce zero-extended 1.
  - 7 sll; 8 srl; 9 sra. Shift amount = SrcB[$clog2(WIDTH)-1:0].
  - 10 pass SrcB (lui). Others → 0.
- Branch: Funct3E selects the condition:
  - 000 eq; 001 ne; 100 lt (signed); 101 ge (signed); 110 ltu; 111 geu; other → not taken.
  - PCSrcE = JumpE | (BranchE & taken).
- PCTargetE = JalrE ? {ALU add result[WIDTH-1:1],1'b0} : PCE+ImmExtE. Wrap modulo 2^WIDTH.
- Multiplier FSM (MUL_EN=1), states IDLE, BUSY, DONE:
  - IDLE & MulE & !FlushE: latch fwdA/fwdB into internal registers, clear accumulator, counter=0 → BUSY.
  - BUSY: one shift-add step per cycle. Counter reaches WIDTH-1 → DONE.
  - DONE: ALUResultE = low WIDTH bits of product. Next edge → IDLE.
  - MulBusyE = MulE & (state != DONE), combinational. The E instruction therefore occupies WIDTH+1 cycles: WIDTH busy cycles plus one result cycle.
- While MulBusyE: RegWriteE=0, MemWriteE=0, PCSrcE=0, so EX/MEM captures a bubble.
- FlushE in any state: FSM → IDLE and the register is bubbled; no result is written.
- Latched operands are immune to forwarding changes during BUSY.
- Back-to-back MUL: the FSM returns to IDLE and the next MulE restarts it; there is no lost cycle beyond DONE.
- MUL_EN=0: MulE is treated as 0; ALU path only.

Decomposition:
- Package exec_pkg: alu_op_t enum (4-bit encodings above), branch funct3 localparams, fwd_sel_t enum, mul_state_t enum.
- Sub-module mul_iter (start, flush, a, b → busy, done, product) instantiated under generate if MUL_EN.
- ALU stays inline.

Test Plan:
- Forwarding: RD1D=5, ForwardAE=10 with ALUResultM=100, ALUControlD=add, ALUSrcD=1, ImmExtD=3 → ALUResultE=103 one cycle after load.
- Branch: BranchD=1, Funct3D=100, SrcA=-1, SrcB=1, PCD=0x40, ImmExtD=0x10 → PCSrcE=1, PCTargetE=0x50. Repeat with Funct3D=110 → PCSrcE=0.
- JALR: JalrD=1, JumpD=1, SrcA=0x1003, ImmExtD=0 → PCTargetE=0x1002, PCSrcE=1.
- Multiply: MulD=1, SrcA=7, SrcB=6 → MulBusyE=1 and RegWriteE=0 for 32 cycles; cycle 33 ALUResultE=42 with RegWriteE=1. Also SrcA=0xFFFFFFFF, SrcB=2 → 0xFFFFFFFE.
- Flush mid-multiply: assert FlushE on busy cycle 10 → next cycle all outputs 0, MulBusyE=0, FSM IDLE. Follow-up add completes normally.
- Stall/reset: StallE=1 for 3 cycles → outputs hold. Flush+stall together → bubble. rst_n low mid-BUSY → immediate all-zero outputs, MulBusyE=0.
